// File: rtl/battleship_input_ctrl.sv
// Pushbutton front end for the battleship core: synchronize, debounce and edge-detect
// four direction buttons and confirm. Optional auto-repeat on mov when AUTOREPEAT_EN is defined.
module battleship_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 10000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] btn_dir,
  input  logic       btn_confirm,
  output logic [3:0] mov,
  output logic       confirm,
  output logic [3:0] dir_level
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]    ACT_POL = {5{BTN_ACTIVE_LOW}};

  // The repeat counter is sized from REPEAT_DELAY, so the period must not exceed it.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("battleship_input_ctrl: invalid debounce/repeat parameters");
  end

  // Bit 4 carries confirm, bits 3:0 the directions.
  logic [4:0]    raw;
  logic [4:0]    sync1_q, sync2_q;
  logic [4:0]    lvl_q, lvl_prev_q;
  logic [CW-1:0] cnt_q [5];

  assign raw = {btn_confirm, btn_dir};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw ^ ACT_POL;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          lvl_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  logic [3:0] d_dir, d_dir_prev;
  logic       d_cf, d_cf_prev;
  logic       new_press, cf_rise;
  logic [3:0] mov_q;
  logic       confirm_q;

  assign d_dir      = lvl_q[3:0];
  assign d_dir_prev = lvl_prev_q[3:0];
  assign d_cf       = lvl_q[4];
  assign d_cf_prev  = lvl_prev_q[4];
  // Chords and releases back to a single button never qualify: a rising bit AND exactly one held.
  assign new_press  = enable && (|(d_dir & ~d_dir_prev)) && $onehot(d_dir);
  assign cf_rise    = enable && d_cf && !d_cf_prev;

`ifdef AUTOREPEAT_EN
  localparam int unsigned   RW        = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic          rep_act_q, rep_first_q;
  logic [RW-1:0] rep_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mov_q       <= '0;
      confirm_q   <= 1'b0;
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      confirm_q <= cf_rise;
      mov_q     <= '0;
      if (new_press) begin
        mov_q       <= d_dir;
        rep_act_q   <= 1'b1;
        rep_first_q <= 1'b1;
        rep_cnt_q   <= '0;
      end else if (rep_act_q && enable && (d_dir == d_dir_prev)) begin
        // Unchanged level since the armed press means the same single direction is still held.
        if (rep_cnt_q == (rep_first_q ? REP_FIRST : REP_NEXT)) begin
          mov_q       <= d_dir;
          rep_first_q <= 1'b0;
          rep_cnt_q   <= '0;
        end else begin
          rep_cnt_q <= rep_cnt_q + RW'(1);
        end
      end else begin
        rep_act_q   <= 1'b0;
        rep_first_q <= 1'b0;
        rep_cnt_q   <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mov_q     <= '0;
      confirm_q <= 1'b0;
    end else begin
      mov_q     <= new_press ? d_dir : 4'b0000;
      confirm_q <= cf_rise;
    end
  end
`endif

  assign mov       = mov_q;
  assign confirm   = confirm_q;
  assign dir_level = d_dir;

endmodule
